// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: op codes, FSM states
// and a small op classifier.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_SMULH = 3'b001,
    OP_UMULH = 3'b010,
    OP_SDIV  = 3'b011,
    OP_UDIV  = 3'b100
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } muldiv_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_SDIV) || (op == OP_UDIV);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_SMULH) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: right shift-add for multiply, or left
// shift/trial-subtract (restoring) for divide, on a 2N-bit working register.
module muldiv_step #(
  parameter int N = 64
) (
  input  logic           i_div,
  input  logic [2*N-1:0] i_acc,
  input  logic [N-1:0]   i_opd,
  output logic [2*N-1:0] o_acc
);

  logic [N:0] w_sum;
  logic [N:0] w_shl;
  logic [N:0] w_diff;

  // Divide layout is {remainder, quotient}; a set w_diff[N] is the borrow
  // of the trial subtract, meaning the shifted remainder is restored.
  always_comb begin
    w_sum  = {1'b0, i_acc[2*N-1:N]} + {1'b0, i_opd};
    w_shl  = i_acc[2*N-1:N-1];
    w_diff = w_shl - {1'b0, i_opd};
    if (i_div) begin
      if (w_diff[N]) o_acc = {w_shl[N-1:0], i_acc[N-2:0], 1'b0};
      else           o_acc = {w_diff[N-1:0], i_acc[N-2:0], 1'b1};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[N-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*N-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MUL/SMULH/UMULH/SDIV/UDIV unit, one bit per cycle, with
// valid/ready handshakes on request and result sides.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  muldiv_state_t  r_state;
  logic [2:0]     r_op;
  logic           r_neg;
  logic           r_bz;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_opd;

  logic [N-1:0]   w_abs_a;
  logic [N-1:0]   w_abs_b;
  logic           w_sgn;
  logic [2*N-1:0] w_acc_next;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_quo;
  logic [N-1:0]   w_res;
  logic           w_dbz;

  muldiv_step #(.N(N)) u_step (
    .i_div (is_div(r_op)),
    .i_acc (r_acc),
    .i_opd (r_opd),
    .o_acc (w_acc_next)
  );

  // Magnitudes as unsigned N-bit values; the most-negative input maps to
  // 2^(N-1), which is exactly its magnitude.
  always_comb begin
    w_sgn   = is_signed_op(op);
    w_abs_a = (w_sgn && a[N-1]) ? -a : a;
    w_abs_b = (w_sgn && b[N-1]) ? -b : b;
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -r_acc[N-1:0] : r_acc[N-1:0];
    w_dbz  = is_div(r_op) && r_bz;
    case (r_op)
      OP_MUL:   w_res = r_acc[N-1:0];
      OP_SMULH: w_res = w_prod[2*N-1:N];
      OP_UMULH: w_res = r_acc[2*N-1:N];
      OP_SDIV,
      OP_UDIV:  w_res = r_bz ? '0 : w_quo;
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_neg       <= 1'b0;
      r_bz        <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opd       <= '0;
      result      <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_neg   <= is_signed_op(op) && (a[N-1] ^ b[N-1]);
            r_bz    <= (b == '0);
            r_cnt   <= CW'(N);
            r_state <= RUN;
            if (is_div(op)) begin
              r_acc <= {{N{1'b0}}, w_abs_a};
              r_opd <= w_abs_b;
            end else begin
              r_acc <= {{N{1'b0}}, w_abs_b};
              r_opd <= w_abs_a;
            end
          end
        end
        RUN: begin
          if (r_cnt == '0) begin
            result      <= w_res;
            zero        <= (w_res == '0);
            div_by_zero <= w_dbz;
            r_state     <= DONE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at N = 64: vector table plus back-pressure
// and mid-operation reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         zero;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
    logic        d;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issues one request, scrambles inputs after the accept edge, and counts
  // edges until out_valid (bounded), noting any in_ready seen while busy.
  task automatic run_op(input logic [2:0] o, input logic [63:0] va, input logic [63:0] vb,
                        output int lat, output int rdy_bad);
    @(negedge clk);
    op = o; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 3'b111; a = ~va; b = ~vb;
    lat = 0; rdy_bad = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) rdy_bad++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat, rdy_bad, ov_seen;

    vecs.push_back('{OP_MUL,   64'd15, 64'd30, 64'd450, 1'b0, 1'b0});
    vecs.push_back('{OP_UMULH, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                     64'h3FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{OP_SMULH, -64'd10, 64'd5678, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{OP_SMULH, -64'd10, -64'd5678, 64'd0, 1'b1, 1'b0});
    vecs.push_back('{OP_SDIV,  -64'd5678, 64'd30, -64'd189, 1'b0, 1'b0});
    vecs.push_back('{OP_UDIV,  64'd5693, 64'd15, 64'd379, 1'b0, 1'b0});
    vecs.push_back('{OP_SDIV,  64'h8000_0000_0000_0000, -64'd1,
                     64'h8000_0000_0000_0000, 1'b0, 1'b0});
    vecs.push_back('{OP_UDIV,  64'd45, 64'd0, 64'd0, 1'b1, 1'b1});
    vecs.push_back('{OP_SDIV,  -64'd7, 64'd0, 64'd0, 1'b1, 1'b1});
    vecs.push_back('{OP_SDIV,  64'd7, -64'd2, -64'd3, 1'b0, 1'b0});
    vecs.push_back('{OP_MUL,   -64'd3, 64'd7, -64'd21, 1'b0, 1'b0});
    vecs.push_back('{3'b101,   64'd9, 64'd3, 64'd0, 1'b1, 1'b0});
    vecs.push_back('{OP_UDIV,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rdy_bad);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd65);
      chk($sformatf("v%0d_busy_in_ready", i), 64'(rdy_bad), 64'd0);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].z));
      chk($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].d));
      release_result();
    end

    // Back-pressure: result held for 10 cycles, then a pending request is
    // accepted one edge after the result handshake.
    run_op(OP_UDIV, 64'd5693, 64'd15, lat, rdy_bad);
    chk("bp_latency", 64'(lat), 64'd65);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_result", result, 64'd379);
      chk("bp_flags", {62'd0, zero, div_by_zero}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = OP_MUL; a = 64'd15; b = 64'd30;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = '0; b = '0;
    chk("bp_accept_in_ready", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_next_latency", 64'(lat), 64'd65);
    chk("bp_next_result", result, 64'd450);
    release_result();

    // Reset 20 cycles into RUN discards the operation.
    @(negedge clk);
    op = OP_MUL; a = 64'd15; b = 64'd30; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ov_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("midrst_no_stale", 64'(ov_seen), 64'd0);

    run_op(OP_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat, rdy_bad);
    chk("post_rst_latency", 64'(lat), 64'd65);
    chk("post_rst_result", result, 64'h4000_0000_0000_0000);
    release_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
